// File: rtl/snake_body_ctrl_pkg.sv
// Shared encodings and sizes for the snake body controller.
// Grid constants mirror the game-wide word width and centre cell address.
package snake_body_ctrl_pkg;

   localparam int WORD_MSB   = 11;
   localparam logic [WORD_MSB:0] MID_ADDR = 12'h820;
   localparam int BODY_IDX_W = 12;
   localparam int BODY_DEPTH = 1 << BODY_IDX_W;

   typedef enum logic [2:0] {
      BODY_INIT,
      BODY_IDLE,
      BODY_SCAN,
      BODY_WRITE,
      BODY_READ,
      BODY_RESP
   } body_state_t;

endpackage

// File: rtl/body_ptr_wrap.sv
// Ring-buffer pointer arithmetic: ptr +/- offset, wrapping naturally at 2**W.
module body_ptr_wrap #(
   parameter int W = 12
) (
   input  logic [W-1:0] i_ptr,
   input  logic [W-1:0] i_off,
   input  logic         i_sub,
   output logic [W-1:0] o_res
);

   assign o_res = i_sub ? (i_ptr - i_off) : (i_ptr + i_off);

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body circular buffer sequencer over a shared single-port RAM.
// Define SNAKE_SELF_COLLISION_EN to add the per-tick self-collision scan.
module snake_body_ctrl
   import snake_body_ctrl_pkg::*;
#(
   parameter int POS_W = WORD_MSB + 1,
   parameter int IDX_W = BODY_IDX_W,
   parameter logic [POS_W-1:0] INIT_POS = POS_W'(MID_ADDR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick_valid,
   output logic             o_tick_ready,
   input  logic [POS_W-1:0] i_new_head,
   input  logic             i_grow,
   input  logic             i_rd_req,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_ack,
   output logic [POS_W-1:0] o_rd_data,
   output logic [IDX_W-1:0] o_mem_addr,
   output logic             o_mem_we,
   output logic [POS_W-1:0] o_mem_wdata,
   input  logic [POS_W-1:0] i_mem_rdata,
   output logic [IDX_W:0]   o_len,
   output logic             o_collision,
   output logic             o_full,
   output logic             o_tick_done
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [IDX_W:0]   DEPTH_LEN = DEPTH[IDX_W:0];
   localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
   localparam logic [IDX_W:0]   ONE_LEN   = (IDX_W + 1)'(1);

   body_state_t r_state, w_state_next;

   logic [IDX_W-1:0] r_head_ptr, r_tail_ptr, r_mem_addr, w_mem_addr_next;
   logic [IDX_W-1:0] w_head_inc, w_tail_inc, w_read_addr;
   logic [IDX_W:0]   r_len;
   logic [POS_W-1:0] r_new_head, r_mem_wdata, w_mem_wdata_next;
   logic             r_grow, r_rd_oob, r_mem_we, w_mem_we_next;
   logic             w_full, w_rd_oob, w_accept_tick, w_accept_rd;

   assign w_full        = (r_len == DEPTH_LEN);
   assign w_rd_oob      = ({1'b0, i_rd_idx} >= r_len);
   assign w_accept_tick = (r_state == BODY_IDLE) && i_tick_valid;
   assign w_accept_rd   = (r_state == BODY_IDLE) && !i_tick_valid && i_rd_req;

   body_ptr_wrap #(.W(IDX_W)) u_head_inc (
      .i_ptr(r_head_ptr), .i_off(ONE_IDX), .i_sub(1'b0), .o_res(w_head_inc)
   );
   body_ptr_wrap #(.W(IDX_W)) u_tail_inc (
      .i_ptr(r_tail_ptr), .i_off(ONE_IDX), .i_sub(1'b0), .o_res(w_tail_inc)
   );
   body_ptr_wrap #(.W(IDX_W)) u_read (
      .i_ptr(r_head_ptr), .i_off(i_rd_idx), .i_sub(1'b1), .o_res(w_read_addr)
   );

`ifdef SNAKE_SELF_COLLISION_EN
   logic [IDX_W:0]   r_scan_cnt;
   logic [IDX_W-1:0] w_scan_off, w_scan_addr;
   logic             r_collision, w_scan_hit;

   // Slot 0 is issued from IDLE, so SCAN cycle j issues slot j+1 and checks slot j-1.
   assign w_scan_off = (r_state == BODY_SCAN) ? (r_scan_cnt[IDX_W-1:0] + ONE_IDX) : '0;
   assign w_scan_hit = (r_state == BODY_SCAN) && (r_scan_cnt != '0)
                       && (r_grow || (r_scan_cnt != ONE_LEN))
                       && (i_mem_rdata == r_new_head);

   body_ptr_wrap #(.W(IDX_W)) u_scan (
      .i_ptr(r_tail_ptr), .i_off(w_scan_off), .i_sub(1'b0), .o_res(w_scan_addr)
   );

   assign o_collision = r_collision;
`else
   assign o_collision = 1'b0;
`endif

   always_comb begin
      w_state_next     = r_state;
      w_mem_addr_next  = '0;
      w_mem_we_next    = 1'b0;
      w_mem_wdata_next = '0;
      case (r_state)
         BODY_INIT: begin
            w_mem_we_next    = 1'b1;
            w_mem_wdata_next = INIT_POS;
            w_state_next     = BODY_IDLE;
         end
         BODY_IDLE: begin
            if (w_accept_tick) begin
`ifdef SNAKE_SELF_COLLISION_EN
               w_mem_addr_next = w_scan_addr;
               w_state_next    = BODY_SCAN;
`else
               w_state_next    = BODY_WRITE;
`endif
            end else if (w_accept_rd) begin
               w_mem_addr_next = w_rd_oob ? '0 : w_read_addr;
               w_state_next    = BODY_READ;
            end
         end
`ifdef SNAKE_SELF_COLLISION_EN
         BODY_SCAN: begin
            if ((r_scan_cnt + ONE_LEN) < r_len) begin
               w_mem_addr_next = w_scan_addr;
            end
            if (r_scan_cnt == r_len) begin
               w_state_next = BODY_WRITE;
            end
         end
`endif
         BODY_WRITE: begin
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = w_head_inc;
            w_mem_wdata_next = r_new_head;
            w_state_next     = BODY_IDLE;
         end
         BODY_READ: w_state_next = BODY_RESP;
         BODY_RESP: w_state_next = BODY_IDLE;
         default:   w_state_next = BODY_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= BODY_INIT;
         r_head_ptr  <= '0;
         r_tail_ptr  <= '0;
         r_len       <= ONE_LEN;
         r_new_head  <= '0;
         r_grow      <= 1'b0;
         r_rd_oob    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
`ifdef SNAKE_SELF_COLLISION_EN
         r_scan_cnt  <= '0;
         r_collision <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_wdata <= w_mem_wdata_next;
         if (w_accept_tick) begin
            r_new_head <= i_new_head;
            r_grow     <= i_grow && !w_full;
         end
         if (w_accept_rd) begin
            r_rd_oob <= w_rd_oob;
         end
`ifdef SNAKE_SELF_COLLISION_EN
         if (w_accept_tick) begin
            r_scan_cnt <= '0;
         end else if (r_state == BODY_SCAN) begin
            r_scan_cnt <= r_scan_cnt + ONE_LEN;
         end
         if (w_scan_hit) begin
            r_collision <= 1'b1;
         end
`endif
         // Growth keeps the tail; otherwise the tail slot is retired.
         if (r_state == BODY_WRITE) begin
            r_head_ptr <= w_head_inc;
            if (r_grow) begin
               r_len <= r_len + ONE_LEN;
            end else begin
               r_tail_ptr <= w_tail_inc;
            end
         end
      end
   end

   assign o_tick_ready = (r_state == BODY_IDLE);
   assign o_tick_done  = (r_state == BODY_WRITE);
   assign o_rd_ack     = (r_state == BODY_RESP);
   assign o_rd_data    = ((r_state == BODY_RESP) && !r_rd_oob) ? i_mem_rdata : '0;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_we     = r_mem_we;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_len        = r_len;
   assign o_full       = w_full;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl: a full-size instance and a 4-deep instance, each with its own RAM.
module tb_snake_body_ctrl;

   localparam logic [11:0] INIT_EXP = 12'h820;
`ifdef SNAKE_SELF_COLLISION_EN
   localparam logic [31:0] COLL_EXP = 32'd1;
`else
   localparam logic [31:0] COLL_EXP = 32'd0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   logic        a_tick_valid, a_tick_ready, a_grow, a_rd_req, a_rd_ack;
   logic        a_mem_we, a_collision, a_full, a_tick_done;
   logic [11:0] a_new_head, a_rd_data, a_mem_wdata, a_mem_rdata;
   logic [11:0] a_rd_idx, a_mem_addr;
   logic [12:0] a_len;

   logic        b_tick_valid, b_tick_ready, b_grow, b_rd_req, b_rd_ack;
   logic        b_mem_we, b_collision, b_full, b_tick_done;
   logic [11:0] b_new_head, b_rd_data, b_mem_wdata, b_mem_rdata;
   logic [1:0]  b_rd_idx, b_mem_addr;
   logic [2:0]  b_len;

   logic [11:0] ram_a [0:4095];
   logic [11:0] ram_b [0:3];

   always @(posedge clk) begin
      if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
      a_mem_rdata <= ram_a[a_mem_addr];
      if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
      b_mem_rdata <= ram_b[b_mem_addr];
   end

   snake_body_ctrl dut_a (
      .clk(clk), .rst(rst_a),
      .i_tick_valid(a_tick_valid), .o_tick_ready(a_tick_ready),
      .i_new_head(a_new_head), .i_grow(a_grow),
      .i_rd_req(a_rd_req), .i_rd_idx(a_rd_idx),
      .o_rd_ack(a_rd_ack), .o_rd_data(a_rd_data),
      .o_mem_addr(a_mem_addr), .o_mem_we(a_mem_we),
      .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata),
      .o_len(a_len), .o_collision(a_collision),
      .o_full(a_full), .o_tick_done(a_tick_done)
   );

   snake_body_ctrl #(.IDX_W(2)) dut_b (
      .clk(clk), .rst(rst_b),
      .i_tick_valid(b_tick_valid), .o_tick_ready(b_tick_ready),
      .i_new_head(b_new_head), .i_grow(b_grow),
      .i_rd_req(b_rd_req), .i_rd_idx(b_rd_idx),
      .o_rd_ack(b_rd_ack), .o_rd_data(b_rd_data),
      .o_mem_addr(b_mem_addr), .o_mem_we(b_mem_we),
      .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata),
      .o_len(b_len), .o_collision(b_collision),
      .o_full(b_full), .o_tick_done(b_tick_done)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Tick latency counted from the accept edge to the negedge showing tick_done.
   function automatic int exp_lat(input int len);
`ifdef SNAKE_SELF_COLLISION_EN
      return len + 2;
`else
      return 1;
`endif
   endfunction

   task automatic wait_ready(input bit sel);
      for (int i = 0; i < 50; i++) begin
         if (sel ? b_tick_ready : a_tick_ready) break;
         @(negedge clk);
      end
   endtask

   task automatic tick(input bit sel, input logic [11:0] head, input bit grow,
                       input int lat_exp, input string tag);
      int  lat;
      bit  done;
      wait_ready(sel);
      if (sel) begin b_tick_valid = 1'b1; b_new_head = head; b_grow = grow; end
      else     begin a_tick_valid = 1'b1; a_new_head = head; a_grow = grow; end
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 5000) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin a_tick_valid = 1'b0; b_tick_valid = 1'b0; end
         done = sel ? b_tick_done : a_tick_done;
      end
      check({tag, "_lat"}, done ? lat : -1, lat_exp);
      $display("tick %s head=%0h grow=%0b lat=%0d", tag, head, grow, lat);
   endtask

   task automatic rd(input bit sel, input int idx, input logic [11:0] data_exp, input string tag);
      int          lat;
      bit          ack;
      logic [11:0] data;
      wait_ready(sel);
      if (sel) begin b_rd_req = 1'b1; b_rd_idx = idx[1:0]; end
      else     begin a_rd_req = 1'b1; a_rd_idx = idx[11:0]; end
      lat  = 0;
      ack  = 1'b0;
      data = '0;
      while (!ack && lat < 20) begin
         @(negedge clk);
         lat++;
         ack  = sel ? b_rd_ack : a_rd_ack;
         data = sel ? b_rd_data : a_rd_data;
      end
      a_rd_req = 1'b0;
      b_rd_req = 1'b0;
      check({tag, "_lat"}, ack ? lat : -1, 2);
      check({tag, "_data"}, data, data_exp);
      $display("read %s idx=%0d data=%0h lat=%0d", tag, idx, data, lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          done_at, ack_at;
      logic [11:0] rdv;

      rst_a = 1'b1; rst_b = 1'b1;
      a_tick_valid = 1'b0; a_new_head = '0; a_grow = 1'b0; a_rd_req = 1'b0; a_rd_idx = '0;
      b_tick_valid = 1'b0; b_new_head = '0; b_grow = 1'b0; b_rd_req = 1'b0; b_rd_idx = '0;
      repeat (3) @(negedge clk);

      // 1: reset state, INIT write, first read
      check("rst_len", a_len, 1);
      check("rst_ready", a_tick_ready, 0);
      check("rst_ack", a_rd_ack, 0);
      check("rst_rdata", a_rd_data, 0);
      check("rst_we", a_mem_we, 0);
      check("rst_addr", a_mem_addr, 0);
      check("rst_wdata", a_mem_wdata, 0);
      check("rst_coll", a_collision, 0);
      check("rst_full", a_full, 0);
      check("rst_done", a_tick_done, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("init_ready", a_tick_ready, 1);
      check("init_we", a_mem_we, 1);
      check("init_addr", a_mem_addr, 0);
      check("init_wdata", a_mem_wdata, INIT_EXP);
      rd(0, 0, INIT_EXP, "t1_rd0");

      // 2: three growing ticks
      tick(0, 12'h101, 1, exp_lat(1), "t2_a");
      tick(0, 12'h102, 1, exp_lat(2), "t2_b");
      tick(0, 12'h103, 1, exp_lat(3), "t2_c");
      @(negedge clk);
      check("t2_len", a_len, 4);
      rd(0, 0, 12'h103, "t2_rd0");
      rd(0, 1, 12'h102, "t2_rd1");
      rd(0, 2, 12'h101, "t2_rd2");
      rd(0, 3, INIT_EXP, "t2_rd3");

      // 3: non-growing tick retires the tail
      tick(0, 12'h104, 0, exp_lat(4), "t3");
      @(negedge clk);
      check("t3_len", a_len, 4);
      rd(0, 0, 12'h104, "t3_rd0");
      rd(0, 3, 12'h101, "t3_rd3");

      // 4: head onto vacating tail is safe; head onto a mid segment collides
      tick(0, 12'h101, 0, exp_lat(4), "t4_tail");
      @(negedge clk);
      check("t4_tail_coll", a_collision, 0);
      tick(0, 12'h103, 1, exp_lat(4), "t4_mid");
      @(negedge clk);
      check("t4_mid_coll", a_collision, COLL_EXP);
      check("t4_len", a_len, 5);

      // 5: simultaneous tick and read; tick wins, out-of-range read returns 0
      wait_ready(0);
      a_tick_valid = 1'b1; a_new_head = 12'h200; a_grow = 1'b0;
      a_rd_req = 1'b1; a_rd_idx = 12'd5;
      done_at = -1; ack_at = -1; rdv = 12'hfff;
      for (int c = 1; c <= 60 && ack_at < 0; c++) begin
         @(negedge clk);
         if (c == 1) a_tick_valid = 1'b0;
         if (a_tick_done && done_at < 0) done_at = c;
         if (a_rd_ack) begin ack_at = c; rdv = a_rd_data; a_rd_req = 1'b0; end
      end
      a_rd_req = 1'b0;
      check("t5_done_at", done_at, exp_lat(5));
      check("t5_ack_at", ack_at, done_at + 3);
      check("t5_oob_data", rdv, 0);
      $display("race tick_done=%0d rd_ack=%0d data=%0h", done_at, ack_at, rdv);
      check("t5_len", a_len, 5);
      rd(0, 4, 12'h103, "t5_tail");

      // 6: 4-deep instance saturates, wraps, then is reset mid-tick
      tick(1, 12'h001, 1, exp_lat(1), "t6_a");
      tick(1, 12'h002, 1, exp_lat(2), "t6_b");
      tick(1, 12'h003, 1, exp_lat(3), "t6_c");
      @(negedge clk);
      check("t6_full_at4", b_full, 1);
      tick(1, 12'h004, 1, exp_lat(4), "t6_d");
      tick(1, 12'h005, 1, exp_lat(4), "t6_e");
      @(negedge clk);
      check("t6_len", b_len, 4);
      check("t6_full", b_full, 1);
      check("t6_coll", b_collision, 0);
      rd(1, 0, 12'h005, "t6_rd0");
      rd(1, 1, 12'h004, "t6_rd1");
      rd(1, 2, 12'h003, "t6_rd2");
      rd(1, 3, 12'h002, "t6_rd3");

      wait_ready(1);
      b_tick_valid = 1'b1; b_new_head = 12'h006; b_grow = 1'b0;
      @(negedge clk);
      b_tick_valid = 1'b0;
      rst_b = 1'b1;
      #1;
      check("t6_rst_len", b_len, 1);
      check("t6_rst_full", b_full, 0);
      check("t6_rst_ready", b_tick_ready, 0);
      check("t6_rst_done", b_tick_done, 0);
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      check("t6_post_ready", b_tick_ready, 1);
      rd(1, 0, INIT_EXP, "t6_post_rd0");
      rd(1, 1, 12'h000, "t6_post_oob");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
